// File: rtl/comparator_3bit_if.sv
// Operand and result bundle for the traffic-light comparator.
// The controller side (master) drives the operands; the comparator (slave)
// returns the combinational relation flags and the registered match tracking.
interface comparator_3bit_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] comp_with;
    logic             comp;
    logic             comp_lt;
    logic             comp_gt;
    logic             comp_q;
    logic             match_rise;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output val,
        output comp_with,
        input  comp,
        input  comp_lt,
        input  comp_gt,
        input  comp_q,
        input  match_rise,
        input  match_cnt
    );

    modport slave (
        input  val,
        input  comp_with,
        output comp,
        output comp_lt,
        output comp_gt,
        output comp_q,
        output match_rise,
        output match_cnt
    );
endinterface

// File: rtl/comparator_3bit.sv
// Magnitude/equality comparator between the phase timer and the light FSM.
// The relation flags are purely combinational so the FSM next-state logic
// sees equality in the same cycle. The registered side delays equality by one
// cycle, emits a single-cycle pulse on each false-to-true equality edge and
// keeps a saturating count of those edges.
module comparator_3bit #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    comparator_3bit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             eq;
    logic             prev_eq;
    logic             rise;

    assign op_a = bus.val;
    assign op_b = bus.comp_with;

    // Unsigned full-width relation between the operands; exactly one flag is high.
    always_comb begin
        eq          = (op_a == op_b);
        bus.comp    = eq;
        bus.comp_lt = (op_a < op_b);
        bus.comp_gt = (op_a > op_b);
    end

    // An equality edge is equality now with no equality seen at the previous edge,
    // regardless of which operand moved to make it true.
    assign rise = eq & ~prev_eq;

    // Registered equality, edge pulse and saturating edge counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.comp_q     <= 1'b0;
            prev_eq        <= 1'b0;
            bus.match_rise <= 1'b0;
            bus.match_cnt  <= '0;
        end else begin
            bus.comp_q     <= eq;
            prev_eq        <= eq;
            bus.match_rise <= rise;
            if (rise && (bus.match_cnt != CNT_MAX)) begin
                bus.match_cnt <= bus.match_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_comparator_3bit.sv
// Self-checking bench for comparator_3bit: table vectors and an exhaustive
// sweep with the clock stopped, then clocked hand sequences and random
// stimulus checked against an integer reference model. A second instance with
// a 2-bit counter exercises saturation.
module tb_comparator_3bit;
    typedef struct {
        logic [2:0] val;
        logic [2:0] comp_with;
        logic       exp_eq;
        logic       exp_lt;
        logic       exp_gt;
    } vec_t;

    logic clk;
    logic rst;
    logic clk_run;

    int n_checks;
    int n_fail;

    // Reference model state (plain integers, rules applied directly).
    int m_prev;
    int m_q;
    int m_rise;
    int m_cnt8;
    int m_cnt2;

    comparator_3bit_if #(.WIDTH(3), .CNT_W(8)) bus ();
    comparator_3bit_if #(.WIDTH(3), .CNT_W(2)) bus2 ();

    comparator_3bit #(.WIDTH(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    comparator_3bit #(.WIDTH(3), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Clock only toggles once the clocked part of the test begins.
    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkComb(input int v, input int c);
        checkOutput("comp",    32'(bus.comp),    32'(v == c));
        checkOutput("comp_lt", 32'(bus.comp_lt), 32'(v < c));
        checkOutput("comp_gt", 32'(bus.comp_gt), 32'(v > c));
    endtask

    task automatic checkRegs();
        checkOutput("comp_q",      32'(bus.comp_q),      32'(m_q));
        checkOutput("match_rise",  32'(bus.match_rise),  32'(m_rise));
        checkOutput("match_cnt",   32'(bus.match_cnt),   32'(m_cnt8));
        checkOutput("match_rise2", 32'(bus2.match_rise), 32'(m_rise));
        checkOutput("match_cnt2",  32'(bus2.match_cnt),  32'(m_cnt2));
    endtask

    task automatic modelStep(input int v, input int c, input bit r);
        int eq;
        if (r) begin
            m_prev = 0;
            m_q    = 0;
            m_rise = 0;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            eq     = (v == c) ? 1 : 0;
            m_rise = (eq == 1 && m_prev == 0) ? 1 : 0;
            if (m_rise == 1) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            m_q    = eq;
            m_prev = eq;
        end
    endtask

    // One clock cycle: drive away from the edge, check combinational flags,
    // let the edge happen, advance the model and check registered outputs.
    task automatic applyStimulus(input int v, input int c, input bit r);
        @(negedge clk);
        bus.val        = 3'(v);
        bus.comp_with  = 3'(c);
        bus2.val       = 3'(v);
        bus2.comp_with = 3'(c);
        rst            = r;
        #1;
        checkComb(v, c);
        @(posedge clk);
        modelStep(v, c, r);
        #1;
        checkRegs();
    endtask

    initial begin
        vec_t vecs[6];
        int   pulses;
        int   v;
        int   c;
        bit   r;

        n_checks = 0;
        n_fail   = 0;
        clk_run  = 1'b0;
        rst      = 1'b1;
        m_prev   = 0;
        m_q      = 0;
        m_rise   = 0;
        m_cnt8   = 0;
        m_cnt2   = 0;

        vecs[0] = '{3'b001, 3'b110, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{3'b101, 3'b101, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{3'b000, 3'b111, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{3'b111, 3'b111, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{3'b100, 3'b011, 1'b0, 1'b0, 1'b1};

        $display("[TB] combinational vectors with clock stopped");
        foreach (vecs[i]) begin
            bus.val       = vecs[i].val;
            bus.comp_with = vecs[i].comp_with;
            #1;
            checkOutput("tbl_comp",    32'(bus.comp),    32'(vecs[i].exp_eq));
            checkOutput("tbl_comp_lt", 32'(bus.comp_lt), 32'(vecs[i].exp_lt));
            checkOutput("tbl_comp_gt", 32'(bus.comp_gt), 32'(vecs[i].exp_gt));
        end

        $display("[TB] exhaustive operand sweep");
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                bus.val       = 3'(i);
                bus.comp_with = 3'(j);
                #1;
                checkComb(i, j);
                checkOutput("onehot", 32'($countones({bus.comp, bus.comp_lt, bus.comp_gt})), 32'd1);
            end
        end

        clk_run = 1'b1;

        $display("[TB] first match after reset");
        applyStimulus(0, 0, 1'b1);
        applyStimulus(2, 3, 1'b0);
        applyStimulus(2, 3, 1'b0);
        applyStimulus(2, 2, 1'b0);
        checkOutput("first_comp_q", 32'(bus.comp_q), 32'd1);
        checkOutput("first_rise",   32'(bus.match_rise), 32'd1);
        checkOutput("first_cnt",    32'(bus.match_cnt), 32'd1);
        applyStimulus(2, 2, 1'b0);
        checkOutput("after_rise",   32'(bus.match_rise), 32'd0);
        checkOutput("after_cnt",    32'(bus.match_cnt), 32'd1);

        $display("[TB] equality held while operands move");
        applyStimulus(4, 4, 1'b0);
        applyStimulus(6, 6, 1'b0);
        checkOutput("held_rise", 32'(bus.match_rise), 32'd0);
        checkOutput("held_cnt",  32'(bus.match_cnt), 32'd1);

        $display("[TB] reset mid-run with equality true");
        applyStimulus(0, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3, 3, 1'b0);
            applyStimulus(3, 5, 1'b0);
        end
        applyStimulus(3, 3, 1'b0);
        checkOutput("pre_rst_cnt", 32'(bus.match_cnt), 32'd5);
        applyStimulus(3, 3, 1'b1);
        checkOutput("rst_comp_q", 32'(bus.comp_q), 32'd0);
        checkOutput("rst_cnt",    32'(bus.match_cnt), 32'd0);
        checkOutput("rst_rise",   32'(bus.match_rise), 32'd0);
        checkOutput("rst_comp",   32'(bus.comp), 32'd1);
        applyStimulus(3, 3, 1'b0);
        checkOutput("rel_rise", 32'(bus.match_rise), 32'd1);
        checkOutput("rel_cnt",  32'(bus.match_cnt), 32'd1);

        $display("[TB] 2-bit counter saturation");
        applyStimulus(0, 0, 1'b1);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, 1'b0);
            if (bus2.match_rise === 1'b1) pulses++;
            applyStimulus(1, 2, 1'b0);
            if (bus2.match_rise === 1'b1) pulses++;
        end
        checkOutput("sat_cnt",    32'(bus2.match_cnt), 32'd3);
        checkOutput("sat_pulses", 32'(pulses), 32'd5);
        checkOutput("wide_cnt",   32'(bus.match_cnt), 32'd5);

        $display("[TB] randomized stimulus against reference model");
        for (int k = 0; k < 400; k++) begin
            v = int'($urandom_range(0, 7));
            c = ($urandom_range(0, 2) == 0) ? v : int'($urandom_range(0, 7));
            r = ($urandom_range(0, 24) == 0);
            applyStimulus(v, c, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
